mult_checker: RTL and testbench

MULT_CHECKER -- requirements
Module: mult_checker

---
 rtl/mult_check_pkg.sv | 15 +
 rtl/mult_checker_seq_mult.sv | 55 +++++
 rtl/mult_checker.sv | 191 +++++++++++++++++++
 tb/tb_mult_checker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_check_pkg.sv
// Shared types and constants for the multiplier checker.
package mult_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_WAIT_DUT,
    ST_COMPARE,
    ST_HALT
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int TMR_W     = 16;

endpackage

// File: rtl/mult_checker_seq_mult.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle for WIDTH cycles.
// product is the running sum including the current bit, so it is final while done is high.
module seq_mult
  import mult_check_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done    = busy_q && (cnt_q == CNT_W'(1));
  assign product = acc_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_checker.sv
// Checks a DUT multiplier against a local shift-add reference, logging the first failure.
// Define MULT_CHECK_STOP_ON_ERROR_EN to park in HALT after the first failing check.
module mult_checker
  import mult_check_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DUT_TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               dut_valid,
  input  logic [2*WIDTH-1:0] dut_product,
  output logic               ready,
  output logic               check_valid,
  output logic               error,
  output logic               timeout,
  output logic               dropped,
  output logic [WIDTH-1:0]   err_a,
  output logic [WIDTH-1:0]   err_b,
  output logic [2*WIDTH-1:0] err_expected,
  output logic [2*WIDTH-1:0] err_actual,
  output logic [31:0]        pass_count
);

  // state | meaning
  // IDLE: wait for operands | MULT: reference multiply | WAIT_DUT: await DUT product
  // COMPARE: check pulse, result logged | HALT: stopped after failure until reset

  state_e             state_q;
  logic               ready_q, check_valid_q, error_q, timeout_q, dropped_q;
  logic [WIDTH-1:0]   a_q, b_q, err_a_q, err_b_q;
  logic [2*WIDTH-1:0] err_exp_q, err_act_q, dut_prod_q, exp_q;
  logic [31:0]        pass_q;
  logic               dut_got_q;
  logic [TMR_W-1:0]   tmr_q, tmr_dec;
`ifdef MULT_CHECK_STOP_ON_ERROR_EN
  logic               fail_q;
`endif

  logic               mult_start, mult_done;
  logic [2*WIDTH-1:0] mult_product;
  logic               dut_now_valid;
  logic [2*WIDTH-1:0] dut_now;
  logic               cmp_go, cmp_to, cmp_fail;
  logic [2*WIDTH-1:0] cmp_exp, cmp_act;

  assign mult_start    = (state_q == ST_IDLE) && in_valid;
  assign dut_now_valid = dut_got_q || dut_valid;
  assign dut_now       = dut_got_q ? dut_prod_q : dut_product;
  assign tmr_dec       = (tmr_q == '0) ? '0 : tmr_q - TMR_W'(1);

  seq_mult #(.WIDTH(WIDTH)) u_seq_mult (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mult_start),
    .a       (a),
    .b       (b),
    .done    (mult_done),
    .product (mult_product)
  );

  // Result is decided on the edge that enters COMPARE so the check pulse and logs appear together.
  always_comb begin
    cmp_go  = 1'b0;
    cmp_to  = 1'b0;
    cmp_exp = mult_product;
    cmp_act = dut_now;
    case (state_q)
      ST_MULT: cmp_go = mult_done && dut_now_valid;
      ST_WAIT_DUT: begin
        cmp_exp = exp_q;
        if (dut_valid) begin
          cmp_go  = 1'b1;
          cmp_act = dut_product;
        end else if (tmr_q <= TMR_W'(1)) begin
          cmp_go  = 1'b1;
          cmp_to  = 1'b1;
          cmp_act = '0;
        end
      end
      default: cmp_go = 1'b0;
    endcase
    cmp_fail = cmp_to || (cmp_exp != cmp_act);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b1;
      check_valid_q <= 1'b0;
      error_q       <= 1'b0;
      timeout_q     <= 1'b0;
      dropped_q     <= 1'b0;
      err_a_q       <= '0;
      err_b_q       <= '0;
      err_exp_q     <= '0;
      err_act_q     <= '0;
      pass_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      dut_got_q     <= 1'b0;
      dut_prod_q    <= '0;
      exp_q         <= '0;
      tmr_q         <= '0;
`ifdef MULT_CHECK_STOP_ON_ERROR_EN
      fail_q        <= 1'b0;
`endif
    end else begin
      check_valid_q <= 1'b0;
      if (in_valid && !ready_q) dropped_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            dut_got_q  <= dut_valid;
            dut_prod_q <= dut_product;
            tmr_q      <= TMR_W'(DUT_TIMEOUT - 1);
            ready_q    <= 1'b0;
            state_q    <= ST_MULT;
          end
        end
        ST_MULT: begin
          tmr_q <= tmr_dec;
          if (!dut_got_q && dut_valid) begin
            dut_got_q  <= 1'b1;
            dut_prod_q <= dut_product;
          end
          if (mult_done) begin
            exp_q <= mult_product;
            if (!dut_now_valid) state_q <= ST_WAIT_DUT;
          end
        end
        ST_WAIT_DUT: tmr_q <= tmr_dec;
        ST_COMPARE: begin
`ifdef MULT_CHECK_STOP_ON_ERROR_EN
          if (fail_q) begin
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
`else
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
`endif
        end
        ST_HALT: ready_q <= 1'b0;
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase

      if (cmp_go) begin
        state_q       <= ST_COMPARE;
        check_valid_q <= 1'b1;
`ifdef MULT_CHECK_STOP_ON_ERROR_EN
        fail_q        <= cmp_fail;
`endif
        if (cmp_to) timeout_q <= 1'b1;
        if (cmp_fail) begin
          error_q <= 1'b1;
          if (!error_q) begin
            err_a_q   <= a_q;
            err_b_q   <= b_q;
            err_exp_q <= cmp_exp;
            err_act_q <= cmp_act;
          end
        end else if (pass_q != 32'hFFFF_FFFF) begin
          pass_q <= pass_q + 32'd1;
        end
      end
    end
  end

  assign ready        = ready_q;
  assign check_valid  = check_valid_q;
  assign error        = error_q;
  assign timeout      = timeout_q;
  assign dropped      = dropped_q;
  assign err_a        = err_a_q;
  assign err_b        = err_b_q;
  assign err_expected = err_exp_q;
  assign err_actual   = err_act_q;
  assign pass_count   = pass_q;

endmodule

// File: tb/tb_mult_checker.sv
// Randomised and directed bench for mult_checker against a transaction-level model.
module tb_mult_checker;

  localparam int W  = 16;
  localparam int TO = 64;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           dut_valid = 1'b0;
  logic [2*W-1:0] dut_product = '0;
  logic           ready, check_valid, error, timeout, dropped;
  logic [W-1:0]   err_a, err_b;
  logic [2*W-1:0] err_expected, err_actual;
  logic [31:0]    pass_count;

  mult_checker #(.WIDTH(W), .DUT_TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .dut_valid    (dut_valid),
    .dut_product  (dut_product),
    .ready        (ready),
    .check_valid  (check_valid),
    .error        (error),
    .timeout      (timeout),
    .dropped      (dropped),
    .err_a        (err_a),
    .err_b        (err_b),
    .err_expected (err_expected),
    .err_actual   (err_actual),
    .pass_count   (pass_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int             n;
    int             c;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_p;
    logic [2*W-1:0] act_p;
    bit             to;
  } txn_t;

  txn_t q[$];
  int   rst_at  = -1;
  int   drop_at = -1;
  bit   chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%0h want=%0h cycle=%0d", nm, got, want, cyc);
    end
  endtask

  // Cycle offset from acceptance to the check pulse for a DUT response d cycles later (-1: none).
  function automatic int ccyc_off(input int d);
    if (d < 0 || d >= TO) return TO;
    return (d + 1 > W + 1) ? d + 1 : W + 1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    dut_valid = 1'b0;
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    rst_at  = cyc;
    step();
    reset_n = 1'b1;
  endtask

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [2*W-1:0] tp, input int d, input int drop_k,
                         input int extra, input int abort_k);
    txn_t t;
    int   n;
    int   off;
    int   ex;
    ex = extra;
    step();
    n        = cyc;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    if (d == 0) begin
      dut_valid   = 1'b1;
      dut_product = tp;
    end
    off     = ccyc_off(d);
    t.n     = n;
    t.c     = n + off;
    t.a     = ta;
    t.b     = tb;
    t.exp_p = 32'(ta) * 32'(tb);
    t.to    = (d < 0 || d >= TO);
    t.act_p = t.to ? '0 : tp;
    q.push_back(t);
    for (int k = 1; k <= off; k++) begin
      step();
      if (k == abort_k) begin
        reset_n = 1'b0;
        rst_at  = cyc;
        step();
        reset_n = 1'b1;
        return;
      end
      if (k == d) begin
        dut_valid   = 1'b1;
        dut_product = tp;
      end else if (d >= 0 && k > d && ex > 0 && $urandom_range(0, 2) == 0) begin
        dut_valid   = 1'b1;
        dut_product = $urandom;
        ex--;
      end
      if (k == drop_k) begin
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        if (drop_at < 0) drop_at = cyc;
      end
    end
  endtask

  // Per-cycle compare against the transaction model.
  initial begin
    int          c;
    txn_t        t;
    bit          e_cv, e_ready, e_drop;
    logic [31:0] m_pass;
    bit          m_err, m_to;
    logic [W-1:0]   m_ea, m_eb;
    logic [2*W-1:0] m_ee, m_eact;
    m_pass = '0; m_err = 0; m_to = 0; m_ea = '0; m_eb = '0; m_ee = '0; m_eact = '0;
    wait (chk_en);
    forever begin
      @(negedge clock);
      c = cyc;
      if (rst_at >= 0 && c == rst_at + 1) begin
        m_pass = '0; m_err = 0; m_to = 0; m_ea = '0; m_eb = '0; m_ee = '0; m_eact = '0;
        q.delete();
        drop_at = -1;
      end
      e_cv    = 1'b0;
      e_ready = 1'b1;
      if (q.size() > 0) begin
        if (c >= q[0].n + 1) e_ready = 1'b0;
        if (c == q[0].c) begin
          t    = q.pop_front();
          e_cv = 1'b1;
          if (t.to || t.exp_p != t.act_p) begin
            if (!m_err) begin
              m_ea = t.a; m_eb = t.b; m_ee = t.exp_p; m_eact = t.act_p;
            end
            m_err = 1'b1;
            if (t.to) m_to = 1'b1;
          end else if (m_pass != 32'hFFFF_FFFF) begin
            m_pass = m_pass + 32'd1;
          end
        end
      end
      e_drop = (drop_at >= 0 && c > drop_at);
      chk("ready", ready, e_ready);
      chk("check_valid", check_valid, e_cv);
      chk("pass_count", pass_count, m_pass);
      chk("error", error, m_err);
      chk("timeout", timeout, m_to);
      chk("dropped", dropped, e_drop);
      chk("err_a", err_a, m_ea);
      chk("err_b", err_b, m_eb);
      chk("err_expected", err_expected, m_ee);
      chk("err_actual", err_actual, m_eact);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [W-1:0]   ta, tb;
    logic [2*W-1:0] tp;
    int             d, off, dk;
    step();
    step();
    rst_at = cyc;
    step();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    chk("reset_ready", ready, 1'b1);
    chk("reset_pass", pass_count, 32'd0);
    chk("reset_error", error, 1'b0);

    run_txn(16'd3, 16'd5, 32'd15, 2, -1, 0, -1);
    chk("s3x5_cv", check_valid, 1'b1);
    chk("s3x5_pass", pass_count, 32'd1);
    chk("s3x5_err", error, 1'b0);

    run_txn(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 7, -1, 1, -1);
    chk("smax_pass", pass_count, 32'd2);
    chk("smax_err", error, 1'b0);

    run_txn(16'd6, 16'd7, 32'd42, 5, 3, 0, -1);
    chk("sdrop_dropped", dropped, 1'b1);
    chk("sdrop_pass", pass_count, 32'd3);

    run_txn(16'd12, 16'd11, 32'd132, 0, -1, 2, -1);
    chk("ssim_pass", pass_count, 32'd4);

    run_txn(16'd7, 16'd9, 32'd62, 20, -1, 0, -1);
    run_txn(16'd2, 16'd2, 32'd5, 1, -1, 0, -1);
    chk("smis_error", error, 1'b1);
    chk("smis_err_a", err_a, 16'd7);
    chk("smis_err_b", err_b, 16'd9);
    chk("smis_err_exp", err_expected, 32'd63);
    chk("smis_err_act", err_actual, 32'd62);
    chk("smis_pass", pass_count, 32'd4);

    do_reset();
    run_txn(16'd4, 16'd4, 32'd16, -1, -1, 0, -1);
    chk("sto_cv", check_valid, 1'b1);
    chk("sto_timeout", timeout, 1'b1);
    chk("sto_error", error, 1'b1);
    chk("sto_err_act", err_actual, 32'd0);
    chk("sto_err_exp", err_expected, 32'd16);

    run_txn(16'd10, 16'd10, 32'd100, 3, -1, 0, 8);
    chk("srst_ready", ready, 1'b1);
    chk("srst_pass", pass_count, 32'd0);
    chk("srst_error", error, 1'b0);
    chk("srst_timeout", timeout, 1'b0);
    chk("srst_cv", check_valid, 1'b0);
    repeat (20) step();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       begin ta = '0;       tb = W'($urandom); end
        1:       begin ta = 16'hFFFF; tb = W'($urandom); end
        default: begin ta = W'($urandom); tb = W'($urandom); end
      endcase
      d   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      tp  = ($urandom_range(0, 3) != 0) ? 32'(ta) * 32'(tb) : 32'($urandom);
      off = ccyc_off(d);
      dk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, off)) : -1;
      run_txn(ta, tb, tp, d, dk, int'($urandom_range(0, 2)), -1);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
